// File: rtl/mux_4x1_scan_pkg.sv
// Shared definitions for the mux_4x1_scan slice: FSM state encodings, mode
// values and the default key width.
package mux_4x1_scan_pkg;

  localparam int SEL_W_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_4x1_scan_mux.sv
// Combinational 2**SEL_W : 1 bit select, built as two half-width selects
// chosen by the key MSB (mirrors the demux_4x1 fan-out structure).
module mux_4x1
  import mux_4x1_scan_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic [2**SEL_W-1:0] data_in,
  input  logic [SEL_W-1:0]    key,
  output logic                out
);

  localparam int HALF = 2**(SEL_W-1);

  logic [HALF-1:0] lo_half;
  logic [HALF-1:0] hi_half;
  logic            lo_bit;
  logic            hi_bit;

  assign lo_half = data_in[HALF-1:0];
  assign hi_half = data_in[2*HALF-1:HALF];
  assign lo_bit  = lo_half[key[SEL_W-2:0]];
  assign hi_bit  = hi_half[key[SEL_W-2:0]];
  assign out     = key[SEL_W-1] ? hi_bit : lo_bit;

endmodule

// File: rtl/mux_4x1_scan.sv
// Serialises a snapshot of 2**SEL_W parallel lines onto one bit with a
// valid/ready handshake: single-shot by key, or a full wrapping scan from key.
module mux_4x1_scan
  import mux_4x1_scan_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2**SEL_W-1:0] data_in,
  input  logic [SEL_W-1:0]   key,
  input  logic               enable,
  input  logic               mode,
  input  logic               start,
  input  logic               out_ready,
  output logic               data_out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   out_channel,
  output logic               busy,
  output logic               done
);

  localparam int N = 2**SEL_W;
  localparam logic [SEL_W-1:0] LAST_COUNT = SEL_W'(N-1);

  logic [1:0]       state;
  logic [N-1:0]     snapshot;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] count;
  logic             mode_q;

  logic             xfer;
  logic             last_xfer;
  logic [SEL_W-1:0] idx_adv;
  logic [N-1:0]     sel_word;
  logic [SEL_W-1:0] sel_key;
  logic             sel_bit;

  assign xfer      = (state == ST_SEND) && out_valid && out_ready && enable;
  assign last_xfer = xfer && ((mode_q == MODE_SINGLE) || (count == LAST_COUNT));
  assign idx_adv   = idx + SEL_W'(1);

  // In IDLE the mux looks at the live inputs so the first bit is ready the
  // cycle after start; afterwards it previews the next channel of the snapshot.
  assign sel_word = (state == ST_IDLE) ? data_in : snapshot;
  assign sel_key  = (state == ST_IDLE) ? key : idx_adv;

  mux_4x1 #(.SEL_W(SEL_W)) u_mux (
    .data_in (sel_word),
    .key     (sel_key),
    .out     (sel_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      snapshot    <= '0;
      idx         <= '0;
      count       <= '0;
      mode_q      <= MODE_SINGLE;
      data_out    <= 1'b0;
      out_valid   <= 1'b0;
      out_channel <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && enable) begin
            state       <= ST_SEND;
            snapshot    <= data_in;
            idx         <= key;
            count       <= '0;
            mode_q      <= mode;
            out_valid   <= 1'b1;
            data_out    <= sel_bit;
            out_channel <= key;
            busy        <= 1'b1;
          end
        end
        ST_SEND: begin
          if (last_xfer) begin
            state     <= ST_DONE;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end else if (xfer) begin
            idx         <= idx_adv;
            count       <= count + SEL_W'(1);
            data_out    <= sel_bit;
            out_channel <= idx_adv;
            out_valid   <= 1'b1;
          end else begin
            // No transfer: bit/channel hold; valid simply tracks enable.
            out_valid <= enable;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
